// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl_if
//  Description : Bundle between the 5-stage RV32 pipeline and the hazard
//                controller. The pipeline side (master) drives the decoded ID
//                instruction, the EX redirect and the memory handshakes; the
//                controller side (slave) returns the stage enables, bubble /
//                flush controls, EX operand selects and performance counters.
//  Ports       : id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
//                id_regwrite, id_memread, id_memwrite, ex_redirect,
//                imem_ready, dmem_ready                   (pipeline -> ctrl)
//                pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble,
//                ex_mem_en, mem_wb_bubble, fwd_a, fwd_b,
//                stall_cnt, flush_cnt                     (ctrl -> pipeline)
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipe_hazard_ctrl_if #(
    parameter int RF_ADDRESS = 5,
    parameter int CNT_W      = 16
);
    logic                  id_valid;
    logic [RF_ADDRESS-1:0] id_rs1;
    logic [RF_ADDRESS-1:0] id_rs2;
    logic                  id_use_rs1;
    logic                  id_use_rs2;
    logic [RF_ADDRESS-1:0] id_rd;
    logic                  id_regwrite;
    logic                  id_memread;
    logic                  id_memwrite;
    logic                  ex_redirect;
    logic                  imem_ready;
    logic                  dmem_ready;

    logic                  pc_en;
    logic                  if_id_en;
    logic                  if_id_flush;
    logic                  id_ex_en;
    logic                  id_ex_bubble;
    logic                  ex_mem_en;
    logic                  mem_wb_bubble;
    logic [1:0]            fwd_a;
    logic [1:0]            fwd_b;
    logic [CNT_W-1:0]      stall_cnt;
    logic [CNT_W-1:0]      flush_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
               id_regwrite, id_memread, id_memwrite, ex_redirect,
               imem_ready, dmem_ready,
        input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble,
               ex_mem_en, mem_wb_bubble, fwd_a, fwd_b, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
               id_regwrite, id_memread, id_memwrite, ex_redirect,
               imem_ready, dmem_ready,
        output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble,
               ex_mem_en, mem_wb_bubble, fwd_a, fwd_b, stall_cnt, flush_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : Centralised hazard / stall / forwarding controller for the
//                5-stage RV32 pipeline. Tracks a shadow scoreboard of the
//                EX/MEM/WB destinations, interlocks load-use (or every EX
//                dependency when MEM bypass is disabled), freezes on a slow
//                data-memory access, squashes on EX redirects, stalls fetch
//                on a slow instruction memory and selects EX operand bypass.
//                Saturating stall and flush counters are provided.
//  Ports       : clk   - clock
//                reset - synchronous, active-high reset
//                hz    - pipe_hazard_ctrl_if.slave (ID info, handshakes in;
//                        enables, bubbles, fwd selects, counters out)
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int RF_ADDRESS = 5,
    parameter int CNT_W      = 16,
    parameter int FWD_EN     = 1
) (
    input  wire logic           clk,
    input  wire logic           reset,
    pipe_hazard_ctrl_if.slave   hz
);

    localparam logic [RF_ADDRESS-1:0] c_X0      = '0;
    localparam logic [CNT_W-1:0]      c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0]      c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic                  c_MEM_FWD = (FWD_EN != 0) ? 1'b1 : 1'b0;

    localparam logic [1:0] c_FWD_RF  = 2'b00;
    localparam logic [1:0] c_FWD_WB  = 2'b01;
    localparam logic [1:0] c_FWD_MEM = 2'b10;

    // ------------------------------------------------------------------
    // Shadow scoreboard
    // ------------------------------------------------------------------
    logic                  r_ex_valid;
    logic [RF_ADDRESS-1:0] r_ex_rd;
    logic                  r_ex_regwrite;
    logic                  r_ex_memread;
    logic                  r_ex_memaccess;
    logic [RF_ADDRESS-1:0] r_ex_rs1;
    logic [RF_ADDRESS-1:0] r_ex_rs2;
    logic                  r_ex_use_rs1;
    logic                  r_ex_use_rs2;

    logic                  r_mem_valid;
    logic [RF_ADDRESS-1:0] r_mem_rd;
    logic                  r_mem_regwrite;
    logic                  r_mem_memread;
    logic                  r_mem_memaccess;

    // WB only ever acts as a bypass source, so only its write info is kept.
    logic                  r_wb_valid;
    logic [RF_ADDRESS-1:0] r_wb_rd;
    logic                  r_wb_regwrite;

    logic [CNT_W-1:0]      r_stall_cnt;
    logic [CNT_W-1:0]      r_flush_cnt;

    // A producer slot satisfies a consumer source when it really writes a
    // non-zero register equal to a source that is really read.
    function automatic logic f_src_hit(
        input logic                  valid,
        input logic                  regwrite,
        input logic [RF_ADDRESS-1:0] rd,
        input logic [RF_ADDRESS-1:0] src,
        input logic                  use_src
    );
        return valid & regwrite & (rd != c_X0) & use_src & (src == rd);
    endfunction

    // ------------------------------------------------------------------
    // Hazard terms
    // ------------------------------------------------------------------
    logic w_match_ex;
    logic w_freeze;
    logic w_raw;
    logic w_stall_evt;
    logic w_flush_evt;

    assign w_match_ex = hz.id_valid &
        (f_src_hit(r_ex_valid, r_ex_regwrite, r_ex_rd, hz.id_rs1, hz.id_use_rs1) |
         f_src_hit(r_ex_valid, r_ex_regwrite, r_ex_rd, hz.id_rs2, hz.id_use_rs2));

    assign w_freeze = r_mem_valid & r_mem_memaccess & ~hz.dmem_ready;

    // Without MEM->EX bypass every EX producer must drain to WB first.
    assign w_raw = w_match_ex & (r_ex_memread | ~c_MEM_FWD);

    // A redirect that beats raw / imem discards those stalls; a freeze
    // always counts, even with a redirect waiting behind it.
    assign w_stall_evt = ~reset &
        (w_freeze | (~hz.ex_redirect & (w_raw | ~hz.imem_ready)));
    assign w_flush_evt = ~reset & ~w_freeze & hz.ex_redirect;

    // ------------------------------------------------------------------
    // Control outputs (priority: reset > freeze > redirect > raw > imem)
    // ------------------------------------------------------------------
    logic w_pc_en;
    logic w_if_id_en;
    logic w_if_id_flush;
    logic w_id_ex_en;
    logic w_id_ex_bubble;
    logic w_ex_mem_en;
    logic w_mem_wb_bubble;

    always_comb begin
        w_pc_en         = 1'b1;
        w_if_id_en      = 1'b1;
        w_if_id_flush   = 1'b0;
        w_id_ex_en      = 1'b1;
        w_id_ex_bubble  = 1'b0;
        w_ex_mem_en     = 1'b1;
        w_mem_wb_bubble = 1'b0;
        if (reset) begin
            w_pc_en         = 1'b0;
            w_if_id_en      = 1'b0;
            w_if_id_flush   = 1'b1;
            w_id_ex_en      = 1'b0;
            w_id_ex_bubble  = 1'b1;
            w_ex_mem_en     = 1'b0;
            w_mem_wb_bubble = 1'b1;
        end else if (w_freeze) begin
            // Whole front end holds; the stuck MEM op must not retire twice.
            w_pc_en         = 1'b0;
            w_if_id_en      = 1'b0;
            w_id_ex_en      = 1'b0;
            w_ex_mem_en     = 1'b0;
            w_mem_wb_bubble = 1'b1;
        end else if (hz.ex_redirect) begin
            w_if_id_flush   = 1'b1;
            w_id_ex_bubble  = 1'b1;
        end else if (w_raw) begin
            w_pc_en         = 1'b0;
            w_if_id_en      = 1'b0;
            w_id_ex_bubble  = 1'b1;
        end else if (!hz.imem_ready) begin
            // Fetch has nothing yet: hold PC, feed a NOP into ID.
            w_pc_en         = 1'b0;
            w_if_id_flush   = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Operand forwarding for the instruction currently in EX
    // ------------------------------------------------------------------
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;

    always_comb begin
        w_fwd_a = c_FWD_RF;
        w_fwd_b = c_FWD_RF;
        if (!reset && r_ex_valid) begin
            if (c_MEM_FWD && !r_mem_memread &&
                f_src_hit(r_mem_valid, r_mem_regwrite, r_mem_rd, r_ex_rs1, r_ex_use_rs1))
                w_fwd_a = c_FWD_MEM;
            else if (f_src_hit(r_wb_valid, r_wb_regwrite, r_wb_rd, r_ex_rs1, r_ex_use_rs1))
                w_fwd_a = c_FWD_WB;

            if (c_MEM_FWD && !r_mem_memread &&
                f_src_hit(r_mem_valid, r_mem_regwrite, r_mem_rd, r_ex_rs2, r_ex_use_rs2))
                w_fwd_b = c_FWD_MEM;
            else if (f_src_hit(r_wb_valid, r_wb_regwrite, r_wb_rd, r_ex_rs2, r_ex_use_rs2))
                w_fwd_b = c_FWD_WB;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard advance
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex_valid      <= 1'b0;
            r_ex_rd         <= '0;
            r_ex_regwrite   <= 1'b0;
            r_ex_memread    <= 1'b0;
            r_ex_memaccess  <= 1'b0;
            r_ex_rs1        <= '0;
            r_ex_rs2        <= '0;
            r_ex_use_rs1    <= 1'b0;
            r_ex_use_rs2    <= 1'b0;
            r_mem_valid     <= 1'b0;
            r_mem_rd        <= '0;
            r_mem_regwrite  <= 1'b0;
            r_mem_memread   <= 1'b0;
            r_mem_memaccess <= 1'b0;
            r_wb_valid      <= 1'b0;
            r_wb_rd         <= '0;
            r_wb_regwrite   <= 1'b0;
        end else begin
            if (w_id_ex_en) begin
                r_ex_valid     <= hz.id_valid & ~w_id_ex_bubble;
                r_ex_rd        <= hz.id_rd;
                r_ex_regwrite  <= hz.id_regwrite;
                r_ex_memread   <= hz.id_memread;
                r_ex_memaccess <= hz.id_memread | hz.id_memwrite;
                r_ex_rs1       <= hz.id_rs1;
                r_ex_rs2       <= hz.id_rs2;
                r_ex_use_rs1   <= hz.id_use_rs1;
                r_ex_use_rs2   <= hz.id_use_rs2;
            end
            if (w_ex_mem_en) begin
                r_mem_valid     <= r_ex_valid;
                r_mem_rd        <= r_ex_rd;
                r_mem_regwrite  <= r_ex_regwrite;
                r_mem_memread   <= r_ex_memread;
                r_mem_memaccess <= r_ex_memaccess;
            end
            r_wb_valid    <= r_mem_valid & ~w_mem_wb_bubble;
            r_wb_rd       <= r_mem_rd;
            r_wb_regwrite <= r_mem_regwrite;
        end
    end

    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_evt && (r_stall_cnt != c_CNT_MAX))
                r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
            if (w_flush_evt && (r_flush_cnt != c_CNT_MAX))
                r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
        end
    end

    assign hz.pc_en         = w_pc_en;
    assign hz.if_id_en      = w_if_id_en;
    assign hz.if_id_flush   = w_if_id_flush;
    assign hz.id_ex_en      = w_id_ex_en;
    assign hz.id_ex_bubble  = w_id_ex_bubble;
    assign hz.ex_mem_en     = w_ex_mem_en;
    assign hz.mem_wb_bubble = w_mem_wb_bubble;
    assign hz.fwd_a         = w_fwd_a;
    assign hz.fwd_b         = w_fwd_b;
    assign hz.stall_cnt     = r_stall_cnt;
    assign hz.flush_cnt     = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_hazard_ctrl
//  Description : Self-checking bench for pipe_hazard_ctrl. Three instances
//                share one stimulus stream: FWD_EN=1, FWD_EN=0 and a 2-bit
//                counter variant. A pipeline-occupancy model decides each
//                cycle which rule applies and what the outputs must be.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_memread, id_memwrite;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       ex_redirect, imem_ready, dmem_ready;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.RF_ADDRESS(5), .CNT_W(16)) if_f1 ();
    pipe_hazard_ctrl_if #(.RF_ADDRESS(5), .CNT_W(16)) if_f0 ();
    pipe_hazard_ctrl_if #(.RF_ADDRESS(5), .CNT_W(2))  if_s  ();

    assign if_f1.id_valid    = id_valid;    assign if_f0.id_valid    = id_valid;    assign if_s.id_valid    = id_valid;
    assign if_f1.id_rs1      = id_rs1;      assign if_f0.id_rs1      = id_rs1;      assign if_s.id_rs1      = id_rs1;
    assign if_f1.id_rs2      = id_rs2;      assign if_f0.id_rs2      = id_rs2;      assign if_s.id_rs2      = id_rs2;
    assign if_f1.id_use_rs1  = id_use_rs1;  assign if_f0.id_use_rs1  = id_use_rs1;  assign if_s.id_use_rs1  = id_use_rs1;
    assign if_f1.id_use_rs2  = id_use_rs2;  assign if_f0.id_use_rs2  = id_use_rs2;  assign if_s.id_use_rs2  = id_use_rs2;
    assign if_f1.id_rd       = id_rd;       assign if_f0.id_rd       = id_rd;       assign if_s.id_rd       = id_rd;
    assign if_f1.id_regwrite = id_regwrite; assign if_f0.id_regwrite = id_regwrite; assign if_s.id_regwrite = id_regwrite;
    assign if_f1.id_memread  = id_memread;  assign if_f0.id_memread  = id_memread;  assign if_s.id_memread  = id_memread;
    assign if_f1.id_memwrite = id_memwrite; assign if_f0.id_memwrite = id_memwrite; assign if_s.id_memwrite = id_memwrite;
    assign if_f1.ex_redirect = ex_redirect; assign if_f0.ex_redirect = ex_redirect; assign if_s.ex_redirect = ex_redirect;
    assign if_f1.imem_ready  = imem_ready;  assign if_f0.imem_ready  = imem_ready;  assign if_s.imem_ready  = imem_ready;
    assign if_f1.dmem_ready  = dmem_ready;  assign if_f0.dmem_ready  = dmem_ready;  assign if_s.dmem_ready  = dmem_ready;

    pipe_hazard_ctrl #(.RF_ADDRESS(5), .CNT_W(16), .FWD_EN(1)) dut_f1 (.clk(clk), .reset(reset), .hz(if_f1));
    pipe_hazard_ctrl #(.RF_ADDRESS(5), .CNT_W(16), .FWD_EN(0)) dut_f0 (.clk(clk), .reset(reset), .hz(if_f0));
    pipe_hazard_ctrl #(.RF_ADDRESS(5), .CNT_W(2),  .FWD_EN(1)) dut_s  (.clk(clk), .reset(reset), .hz(if_s));

    // Observed control word: {pc_en, if_id_en, if_id_flush, id_ex_en,
    // id_ex_bubble, ex_mem_en, mem_wb_bubble, fwd_a[1:0], fwd_b[1:0]}
    logic [10:0] obs_ctl   [3];
    logic [31:0] obs_stall [3];
    logic [31:0] obs_flush [3];

    always_comb begin
        obs_ctl[0]   = {if_f1.pc_en, if_f1.if_id_en, if_f1.if_id_flush, if_f1.id_ex_en, if_f1.id_ex_bubble,
                        if_f1.ex_mem_en, if_f1.mem_wb_bubble, if_f1.fwd_a, if_f1.fwd_b};
        obs_ctl[1]   = {if_f0.pc_en, if_f0.if_id_en, if_f0.if_id_flush, if_f0.id_ex_en, if_f0.id_ex_bubble,
                        if_f0.ex_mem_en, if_f0.mem_wb_bubble, if_f0.fwd_a, if_f0.fwd_b};
        obs_ctl[2]   = {if_s.pc_en, if_s.if_id_en, if_s.if_id_flush, if_s.id_ex_en, if_s.id_ex_bubble,
                        if_s.ex_mem_en, if_s.mem_wb_bubble, if_s.fwd_a, if_s.fwd_b};
        obs_stall[0] = {16'd0, if_f1.stall_cnt};
        obs_stall[1] = {16'd0, if_f0.stall_cnt};
        obs_stall[2] = {30'd0, if_s.stall_cnt};
        obs_flush[0] = {16'd0, if_f1.flush_cnt};
        obs_flush[1] = {16'd0, if_f0.flush_cnt};
        obs_flush[2] = {30'd0, if_s.flush_cnt};
    end

    // ------------------------------------------------------------------
    // Reference model: which instruction occupies EX, MEM and WB
    // ------------------------------------------------------------------
    typedef struct packed {
        logic       v;
        logic [4:0] rd, rs1, rs2;
        logic       rw, mr, ma, u1, u2;
    } slot_t;

    localparam int A_RESET = 0, A_FREEZE = 1, A_REDIRECT = 2, A_RAW = 3, A_IMEM = 4, A_NORMAL = 5;

    slot_t       m_ex [3], m_mem [3], m_wb [3];
    int unsigned m_stall [3], m_flush [3];
    int          m_fwd   [3];
    int unsigned m_max   [3];
    int          acts    [3];
    logic [10:0] snap_ctl   [3];
    logic [31:0] snap_stall [3], snap_flush [3];
    int          total = 0;
    int          bad   = 0;

    function automatic logic hits(slot_t s, logic [4:0] src, logic u);
        return s.v && s.rw && (s.rd != 5'd0) && u && (src == s.rd);
    endfunction

    function automatic int action(int k);
        logic dep;
        if (reset) return A_RESET;
        if (m_mem[k].v && m_mem[k].ma && !dmem_ready) return A_FREEZE;
        if (ex_redirect) return A_REDIRECT;
        dep = id_valid && (hits(m_ex[k], id_rs1, id_use_rs1) || hits(m_ex[k], id_rs2, id_use_rs2));
        // A loaded value is only ready at WB; without MEM bypass nothing is ready before WB.
        if (dep && (m_fwd[k] == 0 || m_ex[k].mr)) return A_RAW;
        if (!imem_ready) return A_IMEM;
        return A_NORMAL;
    endfunction

    // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en, mem_wb_bubble}
    function automatic logic [6:0] act_ctl(int a);
        case (a)
            A_RESET:    return 7'b0010101;
            A_FREEZE:   return 7'b0000001;
            A_REDIRECT: return 7'b1111110;
            A_RAW:      return 7'b0001110;
            A_IMEM:     return 7'b0111010;
            default:    return 7'b1101010;
        endcase
    endfunction

    function automatic logic [1:0] fwd_sel(int k, logic [4:0] src, logic u);
        if (reset || !m_ex[k].v) return 2'b00;
        if (m_fwd[k] != 0 && !m_mem[k].mr && hits(m_mem[k], src, u)) return 2'b10;
        if (hits(m_wb[k], src, u)) return 2'b01;
        return 2'b00;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 3; k++) begin
            m_ex[k] = '0; m_mem[k] = '0; m_wb[k] = '0;
            m_stall[k] = 0; m_flush[k] = 0;
        end
    endtask

    // One clock: check at the falling edge, advance the model at the rising edge.
    task automatic cycle();
        slot_t ne, nw;
        logic [10:0] exp;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            acts[k] = action(k);
            exp = {act_ctl(acts[k]), fwd_sel(k, m_ex[k].rs1, m_ex[k].u1), fwd_sel(k, m_ex[k].rs2, m_ex[k].u2)};
            check($sformatf("ctl[%0d]", k), {21'd0, obs_ctl[k]}, {21'd0, exp});
            check($sformatf("stall_cnt[%0d]", k), obs_stall[k], m_stall[k]);
            check($sformatf("flush_cnt[%0d]", k), obs_flush[k], m_flush[k]);
            snap_ctl[k] = obs_ctl[k]; snap_stall[k] = obs_stall[k]; snap_flush[k] = obs_flush[k];
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (acts[k] == A_RESET) begin
                m_ex[k] = '0; m_mem[k] = '0; m_wb[k] = '0; m_stall[k] = 0; m_flush[k] = 0;
            end else begin
                nw   = m_mem[k];
                nw.v = m_mem[k].v && (acts[k] != A_FREEZE);
                ne   = '{v: id_valid && acts[k] != A_REDIRECT && acts[k] != A_RAW, rd: id_rd,
                         rs1: id_rs1, rs2: id_rs2, rw: id_regwrite, mr: id_memread,
                         ma: id_memread | id_memwrite, u1: id_use_rs1, u2: id_use_rs2};
                m_wb[k] = nw;
                if (acts[k] != A_FREEZE) begin
                    m_mem[k] = m_ex[k];
                    m_ex[k]  = ne;
                end
                if ((acts[k] == A_FREEZE || acts[k] == A_RAW || acts[k] == A_IMEM) && m_stall[k] < m_max[k])
                    m_stall[k]++;
                if (acts[k] == A_REDIRECT && m_flush[k] < m_max[k])
                    m_flush[k]++;
            end
        end
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2, input logic rw, input logic mr, input logic mw);
        id_valid = v; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        id_regwrite = rw; id_memread = mr; id_memwrite = mw;
    endtask

    task automatic set_nop();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        ex_redirect = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1;
    endtask

    task automatic do_reset(input int n);
        set_nop();
        reset = 1'b1;
        repeat (n) cycle();
        reset = 1'b0;
    endtask

    initial begin
        m_fwd = '{1, 0, 1};
        m_max = '{32'd65535, 32'd65535, 32'd3};
        set_nop();
        reset = 1'b1;
        @(posedge clk); #1;
        model_clear();

        do_reset(2);

        // Load-use: lw x5 ; add x6,x5,x1
        set_id(1, 5, 1, 0, 1, 0, 1, 1, 0); cycle();
        set_id(1, 6, 5, 1, 1, 1, 1, 0, 0); cycle();
        check("lu_pc_en", {31'd0, snap_ctl[0][10]}, 32'd0);
        check("lu_bubble", {31'd0, snap_ctl[0][6]}, 32'd1);
        cycle();
        set_nop(); cycle();
        check("lu_fwd_a", {30'd0, snap_ctl[0][3:2]}, 32'd1);
        check("lu_stall_cnt", snap_stall[0], 32'd1);

        // ALU-ALU: add x5,x1,x2 ; sub x7,x5,x5 (sub held in ID one extra cycle)
        do_reset(1);
        set_id(1, 5, 1, 2, 1, 1, 1, 0, 0); cycle();
        set_id(1, 7, 5, 5, 1, 1, 1, 0, 0); cycle();
        check("alu_f1_no_stall", {31'd0, snap_ctl[0][10]}, 32'd1);
        check("alu_f0_stall", {31'd0, snap_ctl[1][10]}, 32'd0);
        cycle();
        check("alu_f1_fwd_mem", {28'd0, snap_ctl[0][3:0]}, 32'hA);
        set_nop(); cycle();
        check("alu_f0_fwd_wb", {28'd0, snap_ctl[1][3:0]}, 32'h5);

        // Data-memory freeze with a redirect waiting behind it
        do_reset(1);
        set_id(1, 5, 1, 0, 1, 0, 1, 1, 0); cycle();
        set_nop(); cycle();
        dmem_ready = 1'b0; ex_redirect = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("frz_mwb_bubble", {31'd0, snap_ctl[0][4]}, 32'd1);
            check("frz_no_flush", {31'd0, snap_ctl[0][8]}, 32'd0);
        end
        dmem_ready = 1'b1; cycle();
        check("frz_redirect_taken", {31'd0, snap_ctl[0][8]}, 32'd1);
        ex_redirect = 1'b0; cycle();
        check("frz_flush_cnt", snap_flush[0], 32'd1);
        check("frz_stall_cnt", snap_stall[0], 32'd3);

        // Redirect and load-use in the same cycle
        do_reset(1);
        set_id(1, 5, 1, 0, 1, 0, 1, 1, 0); cycle();
        set_id(1, 6, 5, 1, 1, 1, 1, 0, 0); ex_redirect = 1'b1; cycle();
        check("rr_pc_en", {31'd0, snap_ctl[0][10]}, 32'd1);
        check("rr_flush", {31'd0, snap_ctl[0][8]}, 32'd1);
        set_nop(); cycle();
        check("rr_stall_cnt", snap_stall[0], 32'd0);

        // Instruction memory not ready for two cycles
        do_reset(1);
        set_id(1, 3, 1, 2, 1, 1, 1, 0, 0); imem_ready = 1'b0;
        repeat (2) begin
            cycle();
            check("imem_pc_en", {31'd0, snap_ctl[0][10]}, 32'd0);
            check("imem_flush", {31'd0, snap_ctl[0][8]}, 32'd1);
        end
        set_nop(); cycle(); cycle();

        // x0 never creates a dependency
        do_reset(1);
        set_id(1, 0, 1, 0, 1, 0, 1, 1, 0); cycle();
        set_id(1, 6, 0, 0, 1, 1, 1, 0, 0); cycle();
        check("x0_no_stall", {31'd0, snap_ctl[1][10]}, 32'd1);
        set_nop(); cycle();
        check("x0_fwd", {28'd0, snap_ctl[0][3:0]}, 32'd0);

        // Counter saturation on the 2-bit instance
        do_reset(1);
        imem_ready = 1'b0; repeat (5) cycle();
        imem_ready = 1'b1; cycle();
        check("sat_stall_cnt2", snap_stall[2], 32'd3);
        check("sat_stall_cnt16", snap_stall[0], 32'd5);

        // Reset asserted in the middle of a freeze
        do_reset(1);
        set_id(1, 5, 1, 0, 1, 0, 1, 1, 0); cycle();
        set_nop(); cycle();
        dmem_ready = 1'b0; cycle();
        reset = 1'b1; cycle();
        check("rst_frz_ctl", {21'd0, snap_ctl[0]}, {21'd0, 7'b0010101, 4'b0000});
        cycle();
        reset = 1'b0; cycle();
        check("rst_frz_unfrozen", {31'd0, snap_ctl[0][10]}, 32'd1);
        check("rst_frz_stall", snap_stall[0], 32'd0);
        set_nop();

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            logic mr;
            reset = ($urandom_range(0, 99) == 0);
            mr = ($urandom_range(0, 9) < 3);
            set_id($urandom_range(0, 99) < 85, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3) != 0, mr, !mr && ($urandom_range(0, 9) < 2));
            ex_redirect = ($urandom_range(0, 9) == 0);
            imem_ready  = ($urandom_range(0, 99) < 85);
            dmem_ready  = ($urandom_range(0, 99) < 75);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Centralised hazard, stall and forwarding controller for the 5-stage RV32 pipeline (IF/ID/EX/MEM/WB).
- Replaces the fixed load-use detector and the combinational forwarding unit.
- Keeps its own shadow scoreboard of the EX/MEM/WB destination state.
- Adds handshake stalls for variable-latency instruction and data memory, a forwarding-disable mode, and saturating stall/flush performance counters.

Parameters:
RF_ADDRESS, 5, register index width
CNT_W, 16, performance counter width
FWD_EN, 1, 1: MEM->EX and WB->EX bypass active; 0: MEM->EX bypass disabled, interlock instead

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
id_valid  in  1  ID holds a real instruction
id_rs1, id_rs2  in  RF_ADDRESS  ID source registers
id_use_rs1, id_use_rs2  in  1  source actually read (0 for lui/auipc/jal)
id_rd  in  RF_ADDRESS  ID destination
id_regwrite, id_memread, id_memwrite  in  1  ID control
ex_redirect  in  1  taken branch/jump resolved in EX
imem_ready  in  1  fetch data valid this cycle
dmem_ready  in  1  MEM-stage access completes this cycle
pc_en  out  1  PC register load enable
if_id_en  out  1  IF/ID load enable
if_id_flush  out  1  load NOP into IF/ID
id_ex_en  out  1  ID/EX load enable
id_ex_bubble  out  1  load NOP into ID/EX
ex_mem_en  out  1  EX/MEM load enable
mem_wb_bubble  out  1  load NOP into MEM/WB
fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 01 WB data, 10 MEM ALU result
stall_cnt  out  CNT_W  cycles with any stall
flush_cnt  out  CNT_W  redirects taken

Behaviour:

Shadow slots:
- EX, MEM and WB slots each hold {valid, rd, regwrite, memread, memaccess}.
- The EX slot additionally holds {rs1, rs2, use_rs1, use_rs2}.

Reset:
- All slots are invalid and the counters are 0.
- While reset is high: pc_en, if_id_en, id_ex_en and ex_mem_en are 0; if_id_flush, id_ex_bubble and mem_wb_bubble are 1; fwd_a and fwd_b are 00.
- Counters do not increment during reset.

Hazard terms:
- match(slot) = slot.valid & slot.regwrite & slot.rd != 0 & ((id_use_rs1 & id_rs1 == slot.rd) | (id_use_rs2 & id_rs2 == slot.rd)), qualified by id_valid.
- freeze = MEM.valid & MEM.memaccess & !dmem_ready.
- raw: with FWD_EN=1, raw = match(EX) & EX.memread; with FWD_EN=0, raw = match(EX).

Control outputs are combinational. Priority is freeze > ex_redirect > raw > !imem_ready > normal.
- freeze: pc_en, if_id_en, id_ex_en and ex_mem_en are 0; mem_wb_bubble=1. A pending ex_redirect is held, not acted on, and is taken in the cycle freeze drops.
- ex_redirect: pc_en=1 (target loaded), if_id_flush=1, id_ex_bubble=1, ex_mem_en=1. Any simultaneous raw or imem stall is discarded because the ID instruction is squashed.
- raw: pc_en=0, if_id_en=0, id_ex_bubble=1, ex_mem_en=1.
- !imem_ready: pc_en=0, if_id_flush=1, ID advances normally.
- normal: every enable is 1, every bubble/flush is 0.
- Outside freeze and reset, id_ex_en=1; the bubble overrides the loaded content.
- if_id_flush has priority over if_id_en.

Slot update (posedge clk):
- EX slot is loaded from the ID inputs when id_ex_en=1, and becomes invalid if id_ex_bubble or !id_valid.
- MEM slot takes the EX slot when ex_mem_en=1.
- WB slot takes the MEM slot, and becomes invalid if mem_wb_bubble.
- memaccess = memread | memwrite.

Forwarding (per operand, for the EX-slot source):
- Select 10 if MEM.valid, MEM.regwrite, MEM.rd != 0, rd equals the source, use is set, !MEM.memread and FWD_EN=1.
- Otherwise select 01 on a WB match (both modes, since the register file is not write-through).
- Otherwise select 00.
- MEM has priority over WB. x0 never forwards. fwd is 00 when the EX slot is invalid.

Counters:
- stall_cnt increments in any cycle with freeze, raw or !imem_ready, excluding cycles where ex_redirect wins.
- flush_cnt increments on an acted-upon redirect.
- Both saturate at all-ones and are cleared only by reset.

Test Plan:
- lw x5 then add x6,x5,x1 with FWD_EN=1 -> one cycle raw (pc_en=0, id_ex_bubble=1); next cycle the add in EX gets fwd_a=01; stall_cnt=1.
- add x5,x1,x2 then sub x7,x5,x5 with FWD_EN=1 -> no stall, fwd_a=fwd_b=10. The same pair with FWD_EN=0 -> one stall cycle, then fwd_a=fwd_b=01.
- lw in MEM with dmem_ready=0 for 3 cycles while ex_redirect=1 -> 3 frozen cycles with mem_wb_bubble=1 and no flush; the redirect is acted on in the 4th cycle (if_id_flush=1, flush_cnt=1); stall_cnt=3.
- ex_redirect and raw in the same cycle -> redirect wins: pc_en=1, if_id_flush=1, stall_cnt unchanged.
- imem_ready=0 for 2 cycles -> pc_en=0 and if_id_flush=1 both cycles; the downstream slots drain normally.
- Producer writing x0 with a consumer reading x0 -> no stall, fwd=00. With CNT_W=2, force 5 stall cycles -> stall_cnt holds 3. Assert reset mid-freeze -> all slots invalid, counters 0, reset output values held.
